// File: rtl/alu_pkg.sv
// Shared ALU/writeback definitions: widths, branch condition codes, writeback entry
// layout and the ALU opcode constants.
package alu_pkg;

   localparam int DATA_W = 32;
   localparam int REG_W  = 5;

   typedef enum logic [2:0] {
      COND_NE  = 3'd0,
      COND_EQ  = 3'd1,
      COND_GT  = 3'd2,
      COND_LT  = 3'd3,
      COND_GE  = 3'd4,
      COND_LE  = 3'd5,
      COND_OVF = 3'd6,
      COND_AL  = 3'd7
   } cond_e;

   typedef struct packed {
      logic [DATA_W-1:0] result;
      logic [REG_W-1:0]  rd;
      logic              we;
   } wb_entry_t;

   localparam logic [3:0] OP_SUB = 4'h2;
   localparam logic [3:0] OP_ADD = 4'h3;
   localparam logic [3:0] OP_AND = 4'h5;
   localparam logic [3:0] OP_OR  = 4'h6;
   localparam logic [3:0] OP_XOR = 4'h7;
   localparam logic [3:0] OP_SLL = 4'h8;
   localparam logic [3:0] OP_SRL = 4'h9;
   localparam logic [3:0] OP_SRA = 4'hA;

   function automatic logic eval_cond(cond_e c, logic z, logic n, logic v);
      logic hit;
      hit = 1'b1;
      case (c)
         COND_NE:  hit = !z;
         COND_EQ:  hit = z;
         COND_GT:  hit = !z && !n;
         COND_LT:  hit = n;
         COND_GE:  hit = !n;
         COND_LE:  hit = z || n;
         COND_OVF: hit = v;
         default:  hit = 1'b1;
      endcase
      return hit;
   endfunction

endpackage

// File: rtl/alu_wb_stage_if.sv
// ALU-to-writeback bus: input op handshake, writeback handshake, flush and
// condition-code / branch-condition signals.
interface alu_wb_if;
   import alu_pkg::*;

   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_result;
   logic              in_z;
   logic              in_n;
   logic              in_v;
   logic [REG_W-1:0]  in_rd;
   logic              in_we;
   logic              in_setcc;
   logic              flush;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_result;
   logic [REG_W-1:0]  out_rd;
   logic              out_we;
   logic              cc_z;
   logic              cc_n;
   logic              cc_v;
   logic [2:0]        cond;
   logic              cond_true;

   modport master (
      output in_valid, in_result, in_z, in_n, in_v, in_rd, in_we, in_setcc,
             flush, out_ready, cond,
      input  in_ready, out_valid, out_result, out_rd, out_we, cc_z, cc_n, cc_v, cond_true
   );

   modport slave (
      input  in_valid, in_result, in_z, in_n, in_v, in_rd, in_we, in_setcc,
             flush, out_ready, cond,
      output in_ready, out_valid, out_result, out_rd, out_we, cc_z, cc_n, cc_v, cond_true
   );
endinterface

// File: rtl/wb_skid_buf.sv
// Two-entry valid/ready skid buffer of writeback entries; the main register
// drives the output, the skid register absorbs one entry under backpressure.
module wb_skid_buf
   import alu_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   input  logic      flush,
   input  logic      in_valid,
   output logic      in_ready,
   input  wb_entry_t in_data,
   output logic      out_valid,
   input  logic      out_ready,
   output wb_entry_t out_data
);

   wb_entry_t main_reg, main_next;
   wb_entry_t skid_reg, skid_next;
   logic      main_valid_reg, main_valid_next;
   logic      skid_valid_reg, skid_valid_next;
   logic      accept;
   logic      transfer;

   assign in_ready  = !skid_valid_reg && !rst;
   assign accept    = in_valid && in_ready;
   assign transfer  = main_valid_reg && out_ready;
   assign out_valid = main_valid_reg;
   assign out_data  = main_reg;

   always_comb begin
      main_next       = main_reg;
      main_valid_next = main_valid_reg;
      skid_next       = skid_reg;
      skid_valid_next = skid_valid_reg;
      if (flush) begin
         // A transfer in this cycle has already happened downstream; only drop state.
         main_valid_next = 1'b0;
         skid_valid_next = 1'b0;
      end else if (skid_valid_reg) begin
         if (transfer) begin
            main_next       = skid_reg;
            skid_valid_next = 1'b0;
         end
      end else if (!main_valid_reg || transfer) begin
         main_valid_next = accept;
         if (accept) main_next = in_data;
      end else if (accept) begin
         skid_next       = in_data;
         skid_valid_next = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         main_reg       <= '0;
         skid_reg       <= '0;
         main_valid_reg <= 1'b0;
         skid_valid_reg <= 1'b0;
      end else begin
         main_reg       <= main_next;
         skid_reg       <= skid_next;
         main_valid_reg <= main_valid_next;
         skid_valid_reg <= skid_valid_next;
      end
   end

endmodule

// File: rtl/alu_wb_stage.sv
// Execute-to-writeback stage: buffers ALU results for writeback, commits the
// condition codes and evaluates branch conditions against them.
module alu_wb_stage
   import alu_pkg::*;
(
   input  logic     clk,
   input  logic     rst,
   alu_wb_if.slave  bus
);

   wb_entry_t  in_entry;
   wb_entry_t  out_entry;
   logic       accept;
   logic [2:0] cc_in;
   logic [2:0] cc_reg;

   assign in_entry = '{result: bus.in_result, rd: bus.in_rd, we: bus.in_we};
   assign accept   = bus.in_valid && bus.in_ready;
   assign cc_in    = {bus.in_z, bus.in_n, bus.in_v};

   wb_skid_buf u_skid (
      .clk       (clk),
      .rst       (rst),
      .flush     (bus.flush),
      .in_valid  (bus.in_valid),
      .in_ready  (bus.in_ready),
      .in_data   (in_entry),
      .out_valid (bus.out_valid),
      .out_ready (bus.out_ready),
      .out_data  (out_entry)
   );

   assign bus.out_result = out_entry.result;
   assign bus.out_rd     = out_entry.rd;
   assign bus.out_we     = out_entry.we;

   // Flags commit on accept regardless of writeback stall; a flushed op never commits.
   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_cc
         always_ff @(posedge clk) begin
            if (rst)
               cc_reg[gi] <= 1'b0;
            else if (accept && bus.in_setcc && !bus.flush)
               cc_reg[gi] <= cc_in[gi];
         end
      end
   endgenerate

   assign bus.cc_z      = cc_reg[2];
   assign bus.cc_n      = cc_reg[1];
   assign bus.cc_v      = cc_reg[0];
   assign bus.cond_true = eval_cond(cond_e'(bus.cond), cc_reg[2], cc_reg[1], cc_reg[0]);

endmodule
